// File: rtl/sb_arbiter.sv
// Round-robin arbiter sharing one simple_bus slave among N_M masters.
// Owns slave req/start, muxes the owner's fields, and revokes grants that stall.
module sb_arbiter #(
    parameter int N_M     = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_M-1:0]           m_req,
    input  logic [N_M-1:0]           m_start,
    input  logic [N_M*ADDR_W-1:0]    m_addr,
    input  logic [N_M*2-1:0]         m_mode,
    input  logic [N_M*DATA_W-1:0]    m_wdata,
    output logic [N_M-1:0]           m_gnt,
    output logic [N_M-1:0]           m_rdy,
    output logic [DATA_W-1:0]        m_rdata,
    output logic                     s_req,
    input  logic                     s_gnt,
    output logic                     s_start,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [1:0]               s_mode,
    output logic [DATA_W-1:0]        s_wdata,
    input  logic                     s_rdy,
    input  logic [DATA_W-1:0]        s_rdata,
    output logic                     timeout
);

    localparam int OW  = (N_M > 1) ? $clog2(N_M) : 1;
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WC_LAST  = WCW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [OW-1:0]  LAST_RST = OW'(N_M - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [OW-1:0]      owner_r, owner_s;
    logic [OW-1:0]      last_r, last_s;
    logic [WCW-1:0]     wcnt_r, wcnt_s;
    logic [N_M-1:0]     gnt_s;
    logic               sreq_s;
    logic               to_s;
    logic               win_found_s;
    logic [OW-1:0]      win_idx_s;

    // First set request bit scanning upward from ptr+1, wrapping; MSB flags a hit.
    function automatic logic [OW:0] rr_pick(input logic [N_M-1:0] req, input logic [OW-1:0] ptr);
        logic          found;
        logic [OW-1:0] win;
        logic [OW-1:0] idx;
        found = 1'b0;
        win   = {OW{1'b0}};
        for (int i = 1; i <= N_M; i++) begin
            idx = OW'((int'(ptr) + i) % N_M);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Owner field muxes and broadcast read data.
    assign s_addr  = m_addr[owner_r*ADDR_W +: ADDR_W];
    assign s_mode  = m_mode[owner_r*2 +: 2];
    assign s_wdata = m_wdata[owner_r*DATA_W +: DATA_W];
    assign m_rdata = s_rdata;

    // Combinational start forwarding and completion routing.
    always_comb begin
        s_start = 1'b0;
        m_rdy   = {N_M{1'b0}};
        if (state_r == GRANT) begin
            s_start = m_start[owner_r] & s_gnt;
        end else if (state_r == BUSY) begin
            m_rdy[owner_r] = s_rdy;
        end else begin
            s_start = 1'b0;
        end
    end

    // Round-robin winner for the next grant.
    always_comb begin
        {win_found_s, win_idx_s} = rr_pick(m_req, last_r);
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        last_s  = last_r;
        wcnt_s  = wcnt_r;
        gnt_s   = m_gnt;
        sreq_s  = s_req;
        to_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_s = GRANT;
                    owner_s = win_idx_s;
                    gnt_s   = {{(N_M-1){1'b0}}, 1'b1} << win_idx_s;
                    sreq_s  = 1'b1;
                    wcnt_s  = {WCW{1'b0}};
                end else begin
                    gnt_s   = {N_M{1'b0}};
                    sreq_s  = 1'b0;
                end
            end
            GRANT: begin
                // Forwarded start beats a request drop, which beats the timeout.
                if (s_start) begin
                    state_s = BUSY;
                    wcnt_s  = {WCW{1'b0}};
                end else if (!m_req[owner_r]) begin
                    state_s = IDLE;
                    gnt_s   = {N_M{1'b0}};
                    sreq_s  = 1'b0;
                    last_s  = owner_r;
                end else if ((TIMEOUT != 0) && (wcnt_r == WC_LAST)) begin
                    state_s = IDLE;
                    gnt_s   = {N_M{1'b0}};
                    sreq_s  = 1'b0;
                    last_s  = owner_r;
                    to_s    = 1'b1;
                end else begin
                    wcnt_s  = wcnt_r + WCW'(1);
                end
            end
            BUSY: begin
                if (s_rdy) begin
                    state_s = IDLE;
                    gnt_s   = {N_M{1'b0}};
                    sreq_s  = 1'b0;
                    last_s  = owner_r;
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {N_M{1'b0}};
                sreq_s  = 1'b0;
            end
        endcase
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= {OW{1'b0}};
            last_r  <= LAST_RST;
            wcnt_r  <= {WCW{1'b0}};
            m_gnt   <= {N_M{1'b0}};
            s_req   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_r  <= last_s;
            wcnt_r  <= wcnt_s;
            m_gnt   <= gnt_s;
            s_req   <= sreq_s;
            timeout <= to_s;
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed self-checking bench for sb_arbiter (N_M=4, TIMEOUT=16).
module tb_sb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  m_req;
    logic [3:0]  m_start;
    logic [31:0] m_addr;
    logic [7:0]  m_mode;
    logic [31:0] m_wdata;
    logic [3:0]  m_gnt;
    logic [3:0]  m_rdy;
    logic [7:0]  m_rdata;
    logic        s_req;
    logic        s_gnt;
    logic        s_start;
    logic [7:0]  s_addr;
    logic [1:0]  s_mode;
    logic [7:0]  s_wdata;
    logic        s_rdy;
    logic [7:0]  s_rdata;
    logic        timeout;

    int n_checks;
    int n_fail;

    sb_arbiter #(.N_M(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_start(m_start), .m_addr(m_addr), .m_mode(m_mode), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rdy(m_rdy), .m_rdata(m_rdata),
        .s_req(s_req), .s_gnt(s_gnt), .s_start(s_start), .s_addr(s_addr), .s_mode(s_mode),
        .s_wdata(s_wdata), .s_rdy(s_rdy), .s_rdata(s_rdata), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        m_req    = 4'b0000;
        m_start  = 4'b0000;
        m_addr   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        m_mode   = {2'b11, 2'b10, 2'b01, 2'b00};
        m_wdata  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        s_gnt    = 1'b0;
        s_rdy    = 1'b0;
        s_rdata  = 8'h5C;
        do_reset();

        check_eq("rst_gnt", m_gnt, 4'b0000);
        check_eq("rst_sreq", s_req, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        check_eq("rst_sstart", s_start, 1'b0);

        // Single master 2
        m_req = 4'b0100;
        s_gnt = 1'b1;
        #1 check_eq("single_pre_gnt", m_gnt, 4'b0000);
        step();
        check_eq("single_gnt", m_gnt, 4'b0100);
        check_eq("single_sreq", s_req, 1'b1);
        check_eq("single_saddr", s_addr, 8'hA2);
        check_eq("single_smode", s_mode, 2'b10);
        check_eq("single_swdata", s_wdata, 8'hD2);
        check_eq("single_nostart", s_start, 1'b0);
        m_start = 4'b0100;
        #1 check_eq("single_sstart", s_start, 1'b1);
        step();
        m_start = 4'b0000;
        #1 check_eq("single_busy_sstart", s_start, 1'b0);
        check_eq("single_busy_rdy0", m_rdy, 4'b0000);
        step();
        step();
        s_rdy = 1'b1;
        #1 check_eq("single_rdy", m_rdy, 4'b0100);
        check_eq("single_rdata", m_rdata, 8'h5C);
        check_eq("single_gnt_hold", m_gnt, 4'b0100);
        step();
        s_rdy = 1'b0;
        m_req = 4'b0000;
        #1 check_eq("single_gnt_drop", m_gnt, 4'b0000);
        check_eq("single_sreq_drop", s_req, 1'b0);
        check_eq("single_rdy_idle", m_rdy, 4'b0000);

        // Round-robin from reset: 0,1,2,3,0 with one dead cycle between
        do_reset();
        m_req   = 4'b1111;
        m_start = 4'b1111;
        s_rdy   = 1'b1;
        s_gnt   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            step();
            check_eq($sformatf("rr%0d_grant", k), m_gnt, exp_g);
            check_eq($sformatf("rr%0d_start", k), s_start, 1'b1);
            step();
            check_eq($sformatf("rr%0d_busy", k), m_gnt, exp_g);
            check_eq($sformatf("rr%0d_rdy", k), m_rdy, exp_g);
            step();
            if (k == 4) begin
                m_req = 4'b0000;
                m_start = 4'b0000;
                s_rdy = 1'b0;
            end
            #1 check_eq($sformatf("rr%0d_dead", k), m_gnt, 4'b0000);
        end

        // Timeout: master 1 stalls with s_gnt low, master 3 waiting
        m_req = 4'b1010;
        s_gnt = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("to_gnt%0d", i), m_gnt, 4'b0010);
            check_eq($sformatf("to_pulse%0d", i), timeout, 1'b0);
            step();
        end
        check_eq("to_gnt_drop", m_gnt, 4'b0000);
        check_eq("to_pulse", timeout, 1'b1);
        step();
        check_eq("to_next_gnt", m_gnt, 4'b1000);
        check_eq("to_pulse_end", timeout, 1'b0);
        check_eq("to_next_saddr", s_addr, 8'hA3);
        m_req = 4'b0000;
        step();
        check_eq("to_drop_idle", m_gnt, 4'b0000);

        // Start with s_gnt low is dropped; re-issued start is forwarded
        m_req = 4'b0001;
        step();
        check_eq("sg0_gnt", m_gnt, 4'b0001);
        m_start = 4'b0001;
        #1 check_eq("sg0_nostart", s_start, 1'b0);
        step();
        m_start = 4'b0000;
        #1 check_eq("sg0_still_grant", m_gnt, 4'b0001);
        check_eq("sg0_norefly", m_rdy, 4'b0000);
        step();
        s_gnt = 1'b1;
        m_start = 4'b0001;
        #1 check_eq("sg1_start", s_start, 1'b1);
        step();
        m_start = 4'b0000;
        s_rdy = 1'b1;
        #1 check_eq("sg1_rdy", m_rdy, 4'b0001);
        step();
        s_rdy = 1'b0;
        m_req = 4'b0000;
        #1 check_eq("sg1_done", m_gnt, 4'b0000);

        // Simultaneous start and request drop: start wins
        m_req = 4'b0100;
        step();
        check_eq("sim_gnt", m_gnt, 4'b0100);
        m_req = 4'b0000;
        m_start = 4'b0100;
        #1 check_eq("sim_sstart", s_start, 1'b1);
        step();
        m_start = 4'b0000;
        #1 check_eq("sim_busy_gnt", m_gnt, 4'b0100);
        step();
        check_eq("sim_busy_hold", m_gnt, 4'b0100);
        s_rdy = 1'b1;
        #1 check_eq("sim_rdy", m_rdy, 4'b0100);
        step();
        s_rdy = 1'b0;
        #1 check_eq("sim_done", m_gnt, 4'b0000);

        // Reset mid-BUSY, then masters 1 and 3 request
        m_req = 4'b1000;
        m_start = 4'b1000;
        step();
        check_eq("rb_gnt", m_gnt, 4'b1000);
        step();
        m_start = 4'b0000;
        m_req = 4'b1010;
        s_rdy = 1'b1;
        #1 check_eq("rb_busy_rdy", m_rdy, 4'b1000);
        rst_n = 1'b0;
        #1 check_eq("rb_rst_gnt", m_gnt, 4'b0000);
        check_eq("rb_rst_sreq", s_req, 1'b0);
        check_eq("rb_rst_rdy", m_rdy, 4'b0000);
        check_eq("rb_rst_sstart", s_start, 1'b0);
        check_eq("rb_rst_timeout", timeout, 1'b0);
        step();
        s_rdy = 1'b0;
        rst_n = 1'b1;
        step();
        check_eq("rb_first_gnt", m_gnt, 4'b0010);
        check_eq("rb_first_sreq", s_req, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
